// File: rtl/osc_freq_meter.sv
`timescale 1ns/1ps
// Measures a selected free-running oscillator: a ripple prescaler divides it, and the
// synchronised prescaler MSB rising edges are counted over a window of clk cycles.
module osc_freq_meter #(
  parameter int N_CH  = 12,
  parameter int DIV_W = 4,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  osc_in,
  input  logic [SEL_W-1:0] ch_sel,
  input  logic [WIN_W-1:0] win_cycles,
  input  logic             start,
  input  logic             result_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] result,
  output logic             overflow,
  output logic             err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [SEL_W:0]   N_CH_L  = (SEL_W+1)'(N_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_reg, state_next;
  logic [SEL_W-1:0] ch_sel_reg;
  logic [WIN_W-1:0] win_reg;
  logic [WIN_W-1:0] win_cnt_reg;
  logic [1:0]       arm_cnt_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;
  logic             err_reg;
  logic             presc_clr_reg;
  logic             sync1_reg, sync2_reg, edge_reg;

  logic             osc_mux;
  logic             ch_sel_bad;
  logic             msb_rise;
  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] stage_clk;

  assign ch_sel_bad = ({1'b0, ch_sel} >= N_CH_L);

  // ch_sel_reg only changes in IDLE, while the prescaler is held cleared, so mux glitches are harmless.
  always_comb begin
    osc_mux = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel_reg == SEL_W'(i)) osc_mux = osc_in[i];
    end
  end

  for (genvar gi = 0; gi < DIV_W; gi++) begin : g_presc
    logic q_reg;
    if (gi == 0) begin : g_head
      assign stage_clk[gi] = osc_mux;
    end else begin : g_tail
      assign stage_clk[gi] = ~presc_q[gi-1];
    end
    always_ff @(posedge stage_clk[gi] or posedge presc_clr_reg) begin
      if (presc_clr_reg) q_reg <= 1'b0;
      else               q_reg <= ~q_reg;
    end
    assign presc_q[gi] = q_reg;
  end

  assign msb_rise = sync2_reg & ~edge_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start) state_next = ch_sel_bad ? ST_DONE : ST_ARM;
      ST_ARM:     if (arm_cnt_reg == 2'd3) state_next = (win_reg == '0) ? ST_DONE : ST_MEASURE;
      ST_MEASURE: if (win_cnt_reg == WIN_W'(1)) state_next = ST_DONE;
      ST_DONE:    if (result_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      ch_sel_reg    <= '0;
      win_reg       <= '0;
      win_cnt_reg   <= '0;
      arm_cnt_reg   <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      err_reg       <= 1'b0;
      presc_clr_reg <= 1'b1;
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      edge_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      presc_clr_reg <= (state_next == ST_IDLE) || (state_next == ST_DONE);
      sync1_reg     <= presc_q[DIV_W-1];
      sync2_reg     <= sync1_reg;
      edge_reg      <= sync2_reg;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            ch_sel_reg  <= ch_sel;
            win_reg     <= win_cycles;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
            err_reg     <= ch_sel_bad;
            arm_cnt_reg <= '0;
          end
        end
        ST_ARM: begin
          arm_cnt_reg <= arm_cnt_reg + 2'd1;
          win_cnt_reg <= win_reg;
        end
        ST_MEASURE: begin
          win_cnt_reg <= win_cnt_reg - WIN_W'(1);
          if (msb_rise) begin
            if (cnt_reg == CNT_MAX) ovf_reg <= 1'b1;
            else                    cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy         = (state_reg != ST_IDLE);
  assign result_valid = (state_reg == ST_DONE);
  assign result       = cnt_reg;
  assign overflow     = ovf_reg;
  assign err          = err_reg;

endmodule

// File: doc/osc_freq_meter.md
OSC_FREQ_METER -- requirements
Module: osc_freq_meter

Interface
REQ-001 SHALL have parameter N_CH, default 12: number of oscillator channels.
REQ-002 SHALL have parameter DIV_W, default 4: ripple prescaler stages; prescale ratio 2^DIV_W.
REQ-003 SHALL have parameter CNT_W, default 16: edge-count result width.
REQ-004 SHALL have parameter WIN_W, default 16: measurement window length width, in clk cycles.
REQ-005 SHALL have parameter SEL_W, default 4: channel select width; SEL_W must satisfy 2^SEL_W >= N_CH.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port osc_in, input, N_CH: free-running oscillator outputs, asynchronous to clk.
REQ-009 SHALL have port ch_sel, input, SEL_W: channel to measure; sampled on start.
REQ-010 SHALL have port win_cycles, input, WIN_W: window length; sampled on start.
REQ-011 SHALL have port start, input, 1: single-cycle request; honoured only in IDLE.
REQ-012 SHALL have port result_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port result_valid, output, 1: high in DONE.
REQ-015 SHALL have port result, output, CNT_W: prescaled edge count.
REQ-016 SHALL have port overflow, output, 1: count saturated.
REQ-017 SHALL have port err, output, 1: ch_sel >= N_CH at start.

Function
REQ-018 SHALL mux osc_in[ch_sel_latched] into one DIV_W-stage ripple toggle-flop prescaler.
REQ-019 SHALL clock the prescaler from the mux output.
REQ-020 SHALL hold the prescaler asynchronously cleared by a registered clk-domain signal that is asserted in IDLE and DONE.
REQ-021 SHALL pass the prescaler MSB through a 2-flop synchroniser plus an edge-detect register.
REQ-022 SHALL count one rising edge of the synchronised MSB per count increment.
REQ-023 SHALL implement an FSM with states IDLE, ARM, MEASURE, DONE.
REQ-024 IDLE -> ARM on start: latch ch_sel and win_cycles, clear the counter and flags.
REQ-025 ARM SHALL last exactly 4 clk cycles, letting the prescaler release and the synchroniser settle, and SHALL count no edges.
REQ-026 ARM -> MEASURE; MEASURE SHALL last exactly win_cycles clk cycles, counting edges.
REQ-027 MEASURE -> DONE on the cycle after the window ends; result is frozen on entry to DONE.
REQ-028 DONE -> IDLE in the cycle where result_valid and result_ready are both high.
REQ-029 result, overflow and err SHALL remain stable while result_valid is high.
REQ-030 win_cycles == 0: ARM -> DONE directly, result 0, overflow 0.
REQ-031 ch_sel >= N_CH: skip ARM/MEASURE, go straight to DONE with err 1 and result 0.
REQ-032 Counter at 2^CNT_W-1 with a further edge: hold the maximum value and set overflow; no wrap.
REQ-033 start while busy SHALL be ignored; no re-latch, no restart.
REQ-034 ch_sel and win_cycles changes after start SHALL have no effect on the measurement in progress.
REQ-035 The stated count accuracy holds only when osc frequency / 2^DIV_W < clk frequency / 4; above that the result is undefined but the FSM SHALL still complete.
REQ-036 result_ready outside DONE SHALL be ignored.

Reset
REQ-037 rst_n low SHALL asynchronously clear the state to IDLE, busy 0, result_valid 0, result 0, overflow 0, err 0, the counter, synchroniser, edge register and prescaler.
REQ-038 rst_n low mid-MEASURE SHALL abort the measurement; no result is produced after release.
REQ-039 First start SHALL be honoured on the first clk edge after rst_n deasserts.

Verification
REQ-040 The bench SHALL cover: clk 10 ns, osc_in[3] period 20 ns, DIV_W 4, ch_sel 3, win_cycles 320, start -> result 10 (+/-1), overflow 0, err 0, busy high 325 cycles.
REQ-041 The bench SHALL cover: result_ready held low 50 cycles after DONE -> result_valid and result stable for 50 cycles; on ready, 1 cycle later IDLE with busy 0.
REQ-042 The bench SHALL cover: CNT_W 4, win_cycles 1000, osc period 20 ns -> result 15, overflow 1.
REQ-043 The bench SHALL cover: ch_sel 13 with N_CH 12 -> err 1, result 0, DONE within 2 cycles; win_cycles 0 -> result 0, err 0.
REQ-044 The bench SHALL cover: start pulsed again mid-MEASURE, and ch_sel changed mid-MEASURE -> result identical to the undisturbed run.
REQ-045 The bench SHALL cover: rst_n pulsed low mid-MEASURE -> all outputs 0 immediately, no result_valid after release, next start measures normally.
